// File: rtl/tile_map_arbiter.sv
// Tile-map RAM owner: copies the level ROM into the single-port map RAM, then arbitrates
// video reads (fixed priority, bounded run) against two round-robin tank engines.
module tile_map_arbiter #(
  parameter int TILES       = 300,
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 3,
  parameter int VID_MAX_RUN = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  input  logic              t1_req,
  input  logic              t1_we,
  input  logic [ADDR_W-1:0] t1_addr,
  input  logic [DATA_W-1:0] t1_wdata,
  output logic              t1_gnt,
  output logic [DATA_W-1:0] t1_rdata,
  output logic              t1_rvalid,
  input  logic              t2_req,
  input  logic              t2_we,
  input  logic [ADDR_W-1:0] t2_addr,
  input  logic [DATA_W-1:0] t2_wdata,
  output logic              t2_gnt,
  output logic [DATA_W-1:0] t2_rdata,
  output logic              t2_rvalid,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int                RUN_W     = $clog2(VID_MAX_RUN + 1);
  localparam logic [ADDR_W:0]   CNT_LAST  = (ADDR_W+1)'(TILES);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(TILES - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(VID_MAX_RUN);
  localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
  localparam logic [DATA_W-1:0] BORDER    = DATA_W'(1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W:0]   init_cnt, init_cnt_nx;
  logic [RUN_W-1:0]  run_cnt, run_cnt_nx;
  logic              rr_t2, rr_t2_nx;
  logic              tank_pend;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;
  logic              gnt_oob;
  logic              vid_vld_p1, t1_vld_p1, t2_vld_p1, oob_p1;
  logic [DATA_W-1:0] rd_data_p1;

  function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
    return (v == RUN_MAX) ? v : v + RUN_ONE;
  endfunction

  always_comb begin
    state_nx    = state;
    init_cnt_nx = init_cnt;
    run_cnt_nx  = run_cnt;
    rr_t2_nx    = rr_t2;
    init_busy   = 1'b0;
    init_done   = 1'b0;
    vid_gnt     = 1'b0;
    t1_gnt      = 1'b0;
    t2_gnt      = 1'b0;
    rom_addr    = '0;
    ram_addr    = '0;
    ram_we      = 1'b0;
    ram_wdata   = '0;
    sel_addr    = '0;
    sel_we      = 1'b0;
    sel_wdata   = '0;
    gnt_oob     = 1'b0;
    tank_pend   = t1_req | t2_req;
    case (state)
      ST_INIT: begin
        // ROM leads RAM by one cycle: count k fetches ROM[k] and stores ROM[k-1]
        init_busy  = 1'b1;
        run_cnt_nx = '0;
        rom_addr   = init_cnt[ADDR_W-1:0];
        if (init_cnt != '0) begin
          ram_we    = 1'b1;
          ram_addr  = ADDR_W'(init_cnt - CNT_ONE);
          ram_wdata = rom_data;
        end
        if (init_cnt == CNT_LAST) begin
          init_done   = 1'b1;
          state_nx    = ST_RUN;
          init_cnt_nx = '0;
        end else begin
          init_cnt_nx = init_cnt + CNT_ONE;
        end
      end
      default: begin
        vid_gnt = vid_req && !((run_cnt == RUN_MAX) && tank_pend);
        t1_gnt  = !vid_gnt && t1_req && (!rr_t2 || !t2_req);
        t2_gnt  = !vid_gnt && t2_req && !t1_gnt;
        if (vid_gnt) begin
          sel_addr = vid_addr;
        end else if (t1_gnt) begin
          sel_addr  = t1_addr;
          sel_we    = t1_we;
          sel_wdata = t1_wdata;
        end else if (t2_gnt) begin
          sel_addr  = t2_addr;
          sel_we    = t2_we;
          sel_wdata = t2_wdata;
        end
        gnt_oob   = sel_addr > ADDR_LAST;
        ram_addr  = sel_addr;
        ram_we    = sel_we && !gnt_oob;
        ram_wdata = sel_wdata;
        if (t1_gnt)      rr_t2_nx = 1'b1;
        else if (t2_gnt) rr_t2_nx = 1'b0;
        if (t1_gnt || t2_gnt || !tank_pend) run_cnt_nx = '0;
        else if (vid_gnt)                   run_cnt_nx = sat_inc(run_cnt);
        if (init_start) begin
          state_nx    = ST_INIT;
          init_cnt_nx = '0;
        end
      end
    endcase
  end

  // p0 -> p1: grant cycle to RAM data-return cycle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      run_cnt    <= '0;
      rr_t2      <= 1'b0;
      vid_vld_p1 <= 1'b0;
      t1_vld_p1  <= 1'b0;
      t2_vld_p1  <= 1'b0;
      oob_p1     <= 1'b0;
    end else begin
      state      <= state_nx;
      init_cnt   <= init_cnt_nx;
      run_cnt    <= run_cnt_nx;
      rr_t2      <= rr_t2_nx;
      vid_vld_p1 <= vid_gnt;
      t1_vld_p1  <= t1_gnt && !t1_we;
      t2_vld_p1  <= t2_gnt && !t2_we;
      oob_p1     <= gnt_oob;
    end
  end

  assign rd_data_p1 = oob_p1 ? BORDER : ram_rdata;
  assign vid_rvalid = vid_vld_p1;
  assign t1_rvalid  = t1_vld_p1;
  assign t2_rvalid  = t2_vld_p1;
  assign vid_rdata  = vid_vld_p1 ? rd_data_p1 : '0;
  assign t1_rdata   = t1_vld_p1  ? rd_data_p1 : '0;
  assign t2_rdata   = t2_vld_p1  ? rd_data_p1 : '0;

endmodule

// File: tb/tb_tile_map_arbiter.sv
// Directed bench for tile_map_arbiter with behavioural level ROM and map RAM models.
module tb_tile_map_arbiter;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       init_start = 1'b0;
  logic       init_busy, init_done;
  logic       vid_req = 1'b0;
  logic [8:0] vid_addr = '0;
  logic       vid_gnt, vid_rvalid;
  logic [2:0] vid_rdata;
  logic       t1_req = 1'b0, t1_we = 1'b0;
  logic [8:0] t1_addr = '0;
  logic [2:0] t1_wdata = '0;
  logic       t1_gnt, t1_rvalid;
  logic [2:0] t1_rdata;
  logic       t2_req = 1'b0, t2_we = 1'b0;
  logic [8:0] t2_addr = '0;
  logic [2:0] t2_wdata = '0;
  logic       t2_gnt, t2_rvalid;
  logic [2:0] t2_rdata;
  logic [8:0] rom_addr, ram_addr;
  logic [2:0] rom_data = '0;
  logic       ram_we;
  logic [2:0] ram_wdata;
  logic [2:0] ram_rdata = '0;
  logic [2:0] ram [0:511] = '{default: 3'd7};

  int checks = 0;
  int errors = 0;

  tile_map_arbiter dut (
    .Clk(Clk), .Reset(Reset), .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .t1_req(t1_req), .t1_we(t1_we), .t1_addr(t1_addr), .t1_wdata(t1_wdata),
    .t1_gnt(t1_gnt), .t1_rdata(t1_rdata), .t1_rvalid(t1_rvalid),
    .t2_req(t2_req), .t2_we(t2_we), .t2_addr(t2_addr), .t2_wdata(t2_wdata),
    .t2_gnt(t2_gnt), .t2_rdata(t2_rdata), .t2_rvalid(t2_rvalid),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 Clk = ~Clk;

  function automatic logic [2:0] rom_val(input int i);
    if (i < 300) return 3'((i + 2) % 5);
    return 3'd0;
  endfunction

  always @(posedge Clk) begin
    rom_data <= rom_val(int'(rom_addr));
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic sweep(output int cycles, output int dones, output int gnts, output int done_at);
    cycles = 0; dones = 0; gnts = 0; done_at = -1;
    while (init_busy && cycles < 400) begin
      if (init_done) begin dones++; done_at = cycles; end
      if (vid_gnt || t1_gnt || t2_gnt) gnts++;
      cycles++;
      tick();
      #1;
    end
  endtask

  function automatic int ram_bad();
    int bad = 0;
    for (int i = 0; i < 300; i++) if (ram[i] !== rom_val(i)) bad++;
    return bad;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, dn, gn, dat, vg, n;

    // reset state
    tick(); tick();
    #1;
    check("rst_gnts", 32'({vid_gnt, t1_gnt, t2_gnt}), 0);
    check("rst_rvalid", 32'({vid_rvalid, t1_rvalid, t2_rvalid}), 0);
    check("rst_we_done", 32'({ram_we, init_done}), 0);
    check("rst_addrs", 32'({rom_addr, ram_addr}), 0);
    check("rst_busy", 32'(init_busy), 1);

    // power-up copy
    tick();
    Reset = 1'b0;
    #1;
    sweep(cyc, dn, gn, dat);
    check("init_cycles", cyc, 301);
    check("init_dones", dn, 1);
    check("init_done_at", dat, 300);
    check("init_gnts", gn, 0);
    check("init_copy", ram_bad(), 0);
    check("init_no_300", 32'(ram[300]), 7);

    // round-robin alternation, t1 first
    t1_req = 1; t1_we = 0; t1_addr = 10;
    t2_req = 1; t2_we = 0; t2_addr = 11;
    #1;
    check("rr0_t1", 32'({t1_gnt, t2_gnt}), 2);
    tick(); #1;
    check("rr1_t2", 32'({t1_gnt, t2_gnt}), 1);
    check("rr1_t1_rdata", 32'({t1_rvalid, t1_rdata}), 32'({1'b1, rom_val(10)}));
    tick(); #1;
    check("rr2_t1", 32'({t1_gnt, t2_gnt}), 2);
    check("rr2_t2_rdata", 32'({t2_rvalid, t2_rdata}), 32'({1'b1, rom_val(11)}));
    tick(); #1;
    check("rr3_t2", 32'({t1_gnt, t2_gnt}), 1);
    tick();

    // video starvation limit
    t1_req = 1; t1_we = 0; t1_addr = 25;
    t2_req = 0;
    vid_req = 1; vid_addr = 4;
    #1;
    check("vid_first_gnt", 32'(vid_gnt), 1);
    tick(); #1;
    check("vid_rdata", 32'({vid_rvalid, vid_rdata}), 32'({1'b1, rom_val(4)}));
    vg = 1; n = 0;
    while (!t1_gnt && n < 20) begin
      if (vid_gnt) vg++;
      n++;
      tick(); #1;
    end
    check("vid_run_len", vg, 8);
    check("starve_t1_gnt", 32'({vid_gnt, t1_gnt}), 1);
    tick();
    t1_req = 0;
    #1;
    check("starve_t1_rdata", 32'({t1_rvalid, t1_rdata}), 32'({1'b1, rom_val(25)}));
    check("vid_resumes", 32'(vid_gnt), 1);
    tick();

    // out-of-range write and read
    vid_req = 0;
    t2_req = 1; t2_we = 1; t2_addr = 300; t2_wdata = 2;
    #1;
    check("oob_wr_gnt", 32'({t2_gnt, ram_we}), 2);
    tick();
    t2_req = 0; t2_we = 0;
    t1_req = 1; t1_we = 0; t1_addr = 310;
    #1;
    check("oob_rd_gnt", 32'(t1_gnt), 1);
    tick();
    t1_req = 0;
    #1;
    check("oob_rd_border", 32'({t1_rvalid, t1_rdata}), 32'({1'b1, 3'd1}));
    check("oob_ram300", 32'(ram[300]), 7);

    // tank write then video read-back
    check("pre_ram40", 32'(ram[40]), 2);
    t1_req = 1; t1_we = 1; t1_addr = 40; t1_wdata = 0;
    #1;
    check("wr40_gnt", 32'({t1_gnt, ram_we}), 3);
    tick();
    t1_req = 0; t1_we = 0;
    vid_req = 1; vid_addr = 40;
    #1;
    check("rd40_gnt", 32'(vid_gnt), 1);
    tick();
    vid_req = 0;
    #1;
    check("rd40_data", 32'({vid_rvalid, vid_rdata}), 32'({1'b1, 3'd0}));

    // both tanks write tile 41: t2 is next in RR order, t1 lands last
    t1_req = 1; t1_we = 1; t1_addr = 41; t1_wdata = 4;
    t2_req = 1; t2_we = 1; t2_addr = 41; t2_wdata = 3;
    #1;
    check("same_first_t2", 32'({t1_gnt, t2_gnt}), 1);
    tick();
    t2_req = 0; t2_we = 0;
    #1;
    check("same_second_t1", 32'({t1_gnt, t2_gnt}), 2);
    tick();
    t1_req = 0; t1_we = 0;
    vid_req = 1; vid_addr = 41;
    #1;
    tick();
    vid_req = 0;
    #1;
    check("same_last_wins", 32'({vid_rvalid, vid_rdata}), 32'({1'b1, 3'd4}));

    // round restart with a video request held across the copy
    init_start = 1;
    vid_req = 1; vid_addr = 2;
    tick();
    init_start = 0;
    #1;
    check("restart_busy", 32'({init_busy, rom_addr}), 32'({1'b1, 9'd0}));
    sweep(cyc, dn, gn, dat);
    check("reload_cycles", cyc, 301);
    check("reload_dones", dn, 1);
    check("reload_gnts", gn, 0);
    check("pending_vid_gnt", 32'(vid_gnt), 1);
    check("reload_ram40", 32'(ram[40]), 32'(rom_val(40)));
    check("reload_ram41", 32'(ram[41]), 32'(rom_val(41)));
    check("reload_copy", ram_bad(), 0);
    tick();
    vid_req = 0;

    // reset drops a pending read return
    t1_req = 1; t1_we = 0; t1_addr = 7;
    #1;
    check("rst_rd_gnt", 32'(t1_gnt), 1);
    tick();
    t1_req = 0;
    #1;
    check("rst_rd_valid", 32'({t1_rvalid, t1_rdata}), 32'({1'b1, rom_val(7)}));
    Reset = 1;
    #1;
    check("rst_rd_dropped", 32'(t1_rvalid), 0);
    check("rst_rd_state", 32'({init_busy, ram_addr}), 32'({1'b1, 9'd0}));
    tick();
    Reset = 0;
    #1;

    // reset in the middle of the copy restarts from address 0
    repeat (150) tick();
    #1;
    check("mid_copy_addr", 32'(rom_addr), 150);
    Reset = 1;
    #1;
    check("mid_copy_reset", 32'({rom_addr, ram_we}), 0);
    tick();
    Reset = 0;
    #1;
    sweep(cyc, dn, gn, dat);
    check("recopy_cycles", cyc, 301);
    check("recopy_dones", dn, 1);
    check("recopy_copy", ram_bad(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
